// File: rtl/mem_rd_stream_if.sv
// Memory read port plus downstream valid/ready stream for mem_rd_stream.
// master = the read controller, slave = memory and compute stage side.
interface mem_rd_stream_if #(
   parameter int RD_ADDR_WDT = 10,
   parameter int DATA_WDT    = 32
);
   logic [RD_ADDR_WDT-1:0] mem_rd_addr;
   logic                   mem_rd_en;
   logic [DATA_WDT-1:0]    mem_data_out;
   logic                   s_valid;
   logic [DATA_WDT-1:0]    s_data;
   logic                   s_last;
   logic                   s_ready;

   modport master (
      output mem_rd_addr, mem_rd_en, s_valid, s_data, s_last,
      input  mem_data_out, s_ready
   );

   modport slave (
      input  mem_rd_addr, mem_rd_en, s_valid, s_data, s_last,
      output mem_data_out, s_ready
   );
endinterface

// File: rtl/mem_rd_stream.sv
// Read-side memory controller: walks an address range, issues one read per
// cycle under a credit limit, tracks the fixed read latency and streams the
// returned words out through a small first-word-fall-through buffer.
// Optional: define MEM_RD_STRIDE_EN to add a per-transfer address stride.
module mem_rd_stream #(
   parameter int RD_ADDR_WDT = 10,
   parameter int DATA_WDT    = 32,
   parameter int RD_LAT      = 3,
   parameter int FIFO_DEPTH  = 4,
   parameter int LEN_WDT     = RD_ADDR_WDT + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [RD_ADDR_WDT-1:0] base_addr,
   input  logic [LEN_WDT-1:0]     len,
`ifdef MEM_RD_STRIDE_EN
   input  logic [RD_ADDR_WDT-1:0] stride,
`endif
   output logic                   busy,
   output logic                   done,
   mem_rd_stream_if.master        bus
);

   localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t                 state;
   logic [RD_ADDR_WDT-1:0] addr;
   logic [RD_ADDR_WDT-1:0] step;
   logic [LEN_WDT-1:0]     len_q;
   logic [LEN_WDT-1:0]     iss_cnt;
   logic [LEN_WDT-1:0]     iss_nxt;
   logic [LEN_WDT-1:0]     ret_cnt;
   logic                   rd_en;
   logic [RD_LAT-1:0]      vpipe;
   logic [RD_LAT-1:0]      pipe_nxt;
   logic [DATA_WDT-1:0]    fifo_data [FIFO_DEPTH];
   logic                   fifo_last [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic                   tail;
   logic                   tail_last;
   logic                   empty;
   logic                   full;
   logic                   push;
   logic                   pop;
   logic                   hs;
   logic                   credit_nxt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign tail      = vpipe[RD_LAT-1];
   assign tail_last = (ret_cnt == len_q - LEN_WDT'(1));
   assign empty     = (cnt == '0);
   assign full      = (cnt == CNT_W'(FIFO_DEPTH));

   // A returning word is presented directly when the buffer is empty, so the
   // first word reaches s_valid in the same cycle it leaves memory; it is only
   // written into the buffer if it is not consumed in that cycle.
   assign bus.s_valid = !empty || tail;
   assign bus.s_data  = !empty ? fifo_data[rd_ptr] : (tail ? bus.mem_data_out : '0);
   assign bus.s_last  = !empty ? fifo_last[rd_ptr] : (tail && tail_last);
   assign hs          = bus.s_valid && bus.s_ready;
   assign push        = tail && !(empty && bus.s_ready);
   assign pop         = hs && !empty;

   assign bus.mem_rd_en   = rd_en;
   assign bus.mem_rd_addr = addr;

   // Next-cycle view of issue count, latency pipe and buffer occupancy; the
   // registered read enable is decided from these so the credit rule
   // (in-flight reads + buffered words < FIFO_DEPTH) holds in the issue cycle.
   always_comb begin
      iss_nxt    = iss_cnt + LEN_WDT'(rd_en);
      pipe_nxt   = (vpipe << 1) | RD_LAT'(rd_en);
      cnt_nxt    = cnt + CNT_W'(push) - CNT_W'(pop);
      credit_nxt = ($countones(pipe_nxt) + int'(cnt_nxt)) < FIFO_DEPTH;
   end

   // Latency pipe, buffer pointers/occupancy and per-transfer return counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
         ret_cnt <= '0;
      end else begin
         vpipe <= pipe_nxt;
         cnt   <= cnt_nxt;
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (state == IDLE && start) ret_cnt <= '0;
         else if (tail)              ret_cnt <= ret_cnt + LEN_WDT'(1);
      end
   end

   // Buffer storage; contents are only meaningful behind the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= bus.mem_data_out;
         fifo_last[wr_ptr] <= tail_last;
      end
   end

   // Transfer sequencing with registered busy/done/read-enable/address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_en   <= 1'b0;
         addr    <= '0;
         step    <= '0;
         len_q   <= '0;
         iss_cnt <= '0;
      end else begin
         done    <= 1'b0;
         iss_cnt <= iss_nxt;
         if (rd_en) addr <= addr + step;
         case (state)
            IDLE: begin
               if (start) begin
                  len_q   <= len;
                  addr    <= base_addr;
                  iss_cnt <= '0;
`ifdef MEM_RD_STRIDE_EN
                  step    <= stride;
`else
                  step    <= RD_ADDR_WDT'(1);
`endif
                  if (len == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state <= ISSUE;
                     busy  <= 1'b1;
                     rd_en <= credit_nxt;
                  end
               end
            end
            ISSUE: begin
               if (iss_nxt == len_q) begin
                  state <= DRAIN;
                  rd_en <= 1'b0;
               end else begin
                  rd_en <= credit_nxt;
               end
            end
            DRAIN: begin
               if (hs && bus.s_last) begin
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
